// File: rtl/port_in_8_if.sv
// Port-pin bus between the CPU-side logic and the port_in_8 input block.
// Signals:
//   pins       - external port pins, asynchronous to the block clock
//   tris       - direction mask, 1 = input, 0 = output
//   ioc_en     - per-bit interrupt-on-change enable
//   read_en    - one-cycle CPU port-read strobe
//   flag_clr   - clear request for the sticky interrupt-on-change flag
//   data_out   - registered port read value
//   data_valid - one-cycle pulse marking a new data_out
//   ioc_flag   - sticky interrupt-on-change flag
interface port_in_8_if;
    logic [7:0] pins;
    logic [7:0] tris;
    logic [7:0] ioc_en;
    logic       read_en;
    logic       flag_clr;
    logic [7:0] data_out;
    logic       data_valid;
    logic       ioc_flag;

    modport master (
        output pins, tris, ioc_en, read_en, flag_clr,
        input  data_out, data_valid, ioc_flag
    );

    modport slave (
        input  pins, tris, ioc_en, read_en, flag_clr,
        output data_out, data_valid, ioc_flag
    );
endinterface

// File: rtl/port_in_8.sv
// 8-bit input port with a two-stage synchronizer, a stability filter,
// a CPU read register and a sticky interrupt-on-change flag.
// Ports:
//   clock - single clock, all state updates on its rising edge
//   reset - synchronous active-high reset
//   bus   - port_in_8_if.slave (pins/tris/ioc_en/read_en/flag_clr in,
//           data_out/data_valid/ioc_flag out)
// Parameter FILTER (1..15): consecutive stable cycles required before a
// pin change is accepted into the filtered value.
module port_in_8 #(
    parameter int unsigned FILTER = 4
) (
    input  logic        clock,
    input  logic        reset,
    port_in_8_if.slave  bus
);

    localparam logic [3:0] CNT_MAX = 4'(FILTER - 1);

    logic [7:0] sync1_q, sync1_d;
    logic [7:0] sync2_q, sync2_d;
    logic [7:0] prev_q, prev_d;
    logic [7:0] filt_q, filt_d;
    logic [7:0] last_q, last_d;
    logic [7:0] data_out_q, data_out_d;
    logic [3:0] cnt_q, cnt_d;
    logic       data_valid_q, data_valid_d;
    logic       ioc_flag_q, ioc_flag_d;
    logic       mismatch;

    always_comb begin
        sync1_d      = bus.pins;
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        cnt_d        = cnt_q;
        filt_d       = filt_q;
        last_d       = last_q;
        data_out_d   = data_out_q;
        data_valid_d = bus.read_en;
        ioc_flag_d   = ioc_flag_q;

        // Any movement restarts the stability count; once the count has
        // reached FILTER-1 it holds and the stable value is accepted.
        if (sync2_q != prev_q) begin
            cnt_d = 4'd0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            filt_d = sync2_q;
        end

        // Mismatch against the last value the CPU read, masked to enabled
        // input bits; tris/ioc_en act combinationally.
        mismatch = |((filt_q ^ last_q) & bus.ioc_en & bus.tris);

        if (bus.read_en) begin
            data_out_d = filt_q & bus.tris;
            last_d     = filt_q;
        end

        // Set has priority over clear, so a clear request cannot hide a
        // change that is still pending.
        if (mismatch) begin
            ioc_flag_d = 1'b1;
        end else if (bus.flag_clr) begin
            ioc_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q      <= 8'h00;
            sync2_q      <= 8'h00;
            prev_q       <= 8'h00;
            filt_q       <= 8'h00;
            last_q       <= 8'h00;
            data_out_q   <= 8'h00;
            cnt_q        <= 4'd0;
            data_valid_q <= 1'b0;
            ioc_flag_q   <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            filt_q       <= filt_d;
            last_q       <= last_d;
            data_out_q   <= data_out_d;
            cnt_q        <= cnt_d;
            data_valid_q <= data_valid_d;
            ioc_flag_q   <= ioc_flag_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.ioc_flag   = ioc_flag_q;

endmodule

// File: tb/tb_port_in_8.sv
module tb_port_in_8;
    localparam int FILTER = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    port_in_8_if bus ();

    port_in_8 #(.FILTER(FILTER)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pins are delayed two edges, and a synchronized value
    // is accepted once it has been seen FILTER+1 times in a row.
    logic [7:0] m_s1, m_s2, m_filt, m_last, m_dout;
    logic       m_dv, m_flag;
    logic [7:0] hist[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [7:0] s2;
        int run;
        logic mis;
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_filt = 0; m_last = 0; m_dout = 0;
            m_dv = 0; m_flag = 0;
            hist.delete();
            hist.push_back(8'h00);
        end else begin
            s2 = m_s2;
            hist.push_back(s2);
            if (hist.size() > 20) void'(hist.pop_front());
            run = 0;
            for (int i = hist.size() - 1; i >= 0; i--) begin
                if (hist[i] != s2) break;
                run++;
            end
            mis = |((m_filt ^ m_last) & bus.ioc_en & bus.tris);
            if (mis) m_flag = 1'b1;
            else if (bus.flag_clr) m_flag = 1'b0;
            m_dv = bus.read_en;
            if (bus.read_en) begin
                m_dout = m_filt & bus.tris;
                m_last = m_filt;
            end
            if (run >= FILTER + 1) m_filt = s2;
            m_s2 = m_s1;
            m_s1 = bus.pins;
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check("data_out", bus.data_out, m_dout);
        check("data_valid", 8'(bus.data_valid), 8'(m_dv));
        check("ioc_flag", 8'(bus.ioc_flag), 8'(m_flag));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_read();
        bus.read_en = 1'b1; step(); bus.read_en = 1'b0;
    endtask

    task automatic do_clr();
        bus.flag_clr = 1'b1; step(); bus.flag_clr = 1'b0;
    endtask

    initial begin
        int hold;
        reset = 1'b1;
        bus.pins = 8'h00; bus.tris = 8'hFF; bus.ioc_en = 8'h00;
        bus.read_en = 1'b0; bus.flag_clr = 1'b0;
        step(); step();
        check("rst_data_out", bus.data_out, 8'h00);
        check("rst_data_valid", 8'(bus.data_valid), 8'h00);
        check("rst_ioc_flag", 8'(bus.ioc_flag), 8'h00);
        reset = 1'b0;
        run(8);

        // Filter latency: early read sees old value, read at edge 7 sees A5
        bus.pins = 8'hA5;
        run(5);
        do_read();
        check("early_read", bus.data_out, 8'h00);
        check("early_valid", 8'(bus.data_valid), 8'h01);
        run(1);
        do_read();
        check("read_e7", bus.data_out, 8'hA5);
        check("read_e7_valid", 8'(bus.data_valid), 8'h01);
        step();
        check("valid_one_cycle", 8'(bus.data_valid), 8'h00);

        // Interrupt on change of bit 3
        bus.ioc_en = 8'h08;
        bus.pins = 8'hAD;
        run(7);
        check("ioc_before_e7", 8'(bus.ioc_flag), 8'h00);
        step();
        check("ioc_at_e7", 8'(bus.ioc_flag), 8'h01);
        do_clr();
        check("clr_while_mismatch", 8'(bus.ioc_flag), 8'h01);
        do_read();
        check("read_in_mismatch", 8'(bus.ioc_flag), 8'h01);
        do_clr();
        check("clr_after_read", 8'(bus.ioc_flag), 8'h00);

        // Clear in the very cycle mismatch first asserts: set wins
        bus.pins = 8'hA5;
        run(7);
        bus.flag_clr = 1'b1; step(); bus.flag_clr = 1'b0;
        check("set_beats_clr", 8'(bus.ioc_flag), 8'h01);
        do_read();
        do_clr();
        check("clr_final", 8'(bus.ioc_flag), 8'h00);

        // Short glitch is filtered out
        bus.ioc_en = 8'hFF;
        bus.pins = 8'h00;
        run(8);
        do_read();
        do_clr();
        check("pre_glitch_flag", 8'(bus.ioc_flag), 8'h00);
        bus.pins = 8'h01;
        run(3);
        bus.pins = 8'h00;
        run(10);
        check("glitch_flag", 8'(bus.ioc_flag), 8'h00);
        do_read();
        check("glitch_read", bus.data_out, 8'h00);

        // Output-direction bits read as 0 and never raise the flag
        bus.ioc_en = 8'h00;
        bus.tris = 8'h0F;
        bus.pins = 8'hFF;
        run(8);
        do_read();
        check("tris_mask_read", bus.data_out, 8'h0F);
        bus.ioc_en = 8'hF0;
        bus.pins = 8'h0F;
        run(8);
        bus.pins = 8'hFF;
        run(8);
        check("tris_mask_ioc", 8'(bus.ioc_flag), 8'h00);

        // Reset mid-filter discards the pending change
        bus.tris = 8'hFF;
        bus.ioc_en = 8'h00;
        bus.pins = 8'h00;
        run(8);
        do_read();
        bus.pins = 8'hFF;
        run(4);
        reset = 1'b1; bus.read_en = 1'b1; bus.flag_clr = 1'b1;
        step();
        reset = 1'b0; bus.read_en = 1'b0; bus.flag_clr = 1'b0;
        check("midrst_data_out", bus.data_out, 8'h00);
        check("midrst_valid", 8'(bus.data_valid), 8'h00);
        check("midrst_flag", 8'(bus.ioc_flag), 8'h00);
        run(5);
        bus.read_en = 1'b1;
        step();
        check("midrst_e10", bus.data_out, 8'h00);
        step();
        check("midrst_e11", bus.data_out, 8'h00);
        check("b2b_valid", 8'(bus.data_valid), 8'h01);
        step();
        bus.read_en = 1'b0;
        check("midrst_e12", bus.data_out, 8'hFF);

        // Randomized traffic against the model
        hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 1) == 0)
                    bus.pins = bus.pins ^ (8'h01 << $urandom_range(0, 7));
                else
                    bus.pins = 8'($urandom);
                hold = $urandom_range(1, 9);
            end
            hold--;
            if ($urandom_range(0, 15) == 0) bus.tris = 8'($urandom);
            if ($urandom_range(0, 15) == 0) bus.ioc_en = 8'($urandom);
            bus.read_en = ($urandom_range(0, 3) == 0);
            bus.flag_clr = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 63) == 0);
            step();
        end
        reset = 1'b0;
        bus.read_en = 1'b0;
        bus.flag_clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/port_in_8.md
PORT_IN_8 -- requirements
Module: port_in_8

Interface
REQ-001 Parameter FILTER, default 4, meaning consecutive stable cycles required before a pin change is accepted; legal range 1..15.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on the rising edge of clock.
REQ-004 pins  input  8  external port pins, asynchronous to clock.
REQ-005 tris  input  8  direction mask from the 8-bit direction register; 1=input, 0=output; reset value of the source register is 8'hFF.
REQ-006 ioc_en  input  8  per-bit interrupt-on-change enable.
REQ-007 read_en  input  1  CPU port-read strobe, one cycle per read.
REQ-008 flag_clr  input  1  clears ioc_flag.
REQ-009 data_out  output  8  registered port read value.
REQ-010 data_valid  output  1  one-cycle pulse marking a new data_out.
REQ-011 ioc_flag  output  1  sticky interrupt-on-change flag.

Function
REQ-012 The block SHALL pass pins through a two-stage synchronizer: sync1 <= pins, sync2 <= sync1.
REQ-013 The block SHALL hold prev <= sync2 every cycle and a 4-bit stability counter cnt.
REQ-014 If sync2 != prev (any bit), cnt SHALL load 0.
REQ-015 If sync2 == prev and cnt < FILTER-1, cnt SHALL increment.
REQ-016 If sync2 == prev and cnt == FILTER-1, filt SHALL load sync2; cnt SHALL hold (no wrap).
REQ-017 For a pin change stable before rising edge 0, filt SHALL update at edge FILTER+2 and SHALL NOT update earlier.
REQ-018 A pin glitch shorter than FILTER+1 cycles after synchronization SHALL NOT change filt.
REQ-019 On read_en=1, data_out SHALL load filt & tris at that edge and data_valid SHALL be 1 for exactly the following cycle.
REQ-020 Output-direction bits (tris=0) SHALL read as 0 in data_out.
REQ-021 On read_en=1, snapshot register last SHALL load filt at the same edge.
REQ-022 mismatch = |((filt ^ last) & ioc_en & tris), evaluated combinationally from current register values.
REQ-023 mismatch=1 SHALL set ioc_flag at the next edge, i.e. edge FILTER+3 after a pin change.
REQ-024 ioc_flag SHALL remain 1 until a cycle with flag_clr=1 and mismatch=0.
REQ-025 flag_clr and mismatch asserted in the same cycle: set SHALL win, and ioc_flag SHALL stay 1.
REQ-026 read_en in a mismatch cycle: the flag SHALL still set from the old last; mismatch clears the following cycle because last is updated.
REQ-027 Changing tris or ioc_en SHALL take effect on mismatch and data_out combinationally in the same cycle; no pipeline delay.
REQ-028 Back-to-back read_en SHALL produce one data_valid pulse per strobe with no lost reads.

Reset
REQ-029 reset=1 at a rising edge SHALL clear sync1, sync2, prev, filt, last, data_out, cnt, data_valid and ioc_flag to 0.
REQ-030 reset SHALL take priority over read_en, flag_clr and filter updates in the same cycle.
REQ-031 A reset mid-filter SHALL discard the pending change; after reset release the change SHALL require the full FILTER+2 edges.

Verification
REQ-032 FILTER=4, tris=FF, pins 00->A5 before edge 0, read_en at edge 7 -> data_out=A5 and data_valid=1 after edge 7; a read at edge 5 -> data_out=00.
REQ-033 pins 00->01 for 3 cycles then back to 00, FILTER=4 -> filt stays 00 and ioc_flag stays 0.
REQ-034 ioc_en=08, tris=FF, pins bit3 rises -> ioc_flag=1 at edge 7; flag_clr alone -> still 1 (mismatch); read_en then flag_clr -> ioc_flag=0.
REQ-035 tris=0F, pins=FF stable, read_en -> data_out=0F; ioc_en=F0 with pins toggling F0 -> ioc_flag stays 0.
REQ-036 flag_clr=1 in the same cycle mismatch first asserts -> ioc_flag=1 on the next cycle.
REQ-037 reset=1 for one cycle at edge 4 during a pins=FF change -> all outputs 0; filt=FF reached at edge 4+FILTER+3, not before.
